// File: rtl/mw_stage_pkg.sv
// -----------------------------------------------------------------------------
// mw_stage_pkg
// Shared definitions for the M/W pipeline stage of the 5-stage MIPS core:
// opcode/funct constants, the $ra index, Tnew width, writeback decode enums
// and the W-stage register bundle.
// -----------------------------------------------------------------------------
package mw_stage_pkg;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_RORDER = 6'h00;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_JAL    = 6'h03;

  // R-type function codes (Instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_NOP = 6'h00;

  localparam logic [4:0] RA_IDX = 5'd31;
  localparam int         TNEW_W = 2;

  // Where the GRF write address comes from.
  typedef enum logic [1:0] {
    A3_NONE,
    A3_RD,
    A3_RT,
    A3_RA
  } a3_src_e;

  // Which value is written back.
  typedef enum logic [1:0] {
    WD_ZERO,
    WD_ALU,
    WD_DM,
    WD_PC8
  } wd_sel_e;

  // Everything the W stage keeps from the M stage.
  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [31:0]       alu;
    logic [31:0]       dm;
    logic [TNEW_W-1:0] tnew;
    logic              valid;
  } w_regs_t;

  // Tnew counts down one per stage and stops at zero.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/mw_stage_wb_decode.sv
// -----------------------------------------------------------------------------
// wb_decode
// Combinational writeback decoder for the W-stage instruction.
// Ports:
//   opcode  in   Instr_W[31:26]
//   funct   in   Instr_W[5:0]
//   we      out  instruction writes the GRF (before the $0 rule)
//   a3_src  out  source of the write address
//   wd_sel  out  source of the write data
// -----------------------------------------------------------------------------
module wb_decode
  import mw_stage_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       we,
  output a3_src_e    a3_src,
  output wd_sel_e    wd_sel
);

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    we     = 1'b0;
    a3_src = A3_NONE;
    wd_sel = WD_ZERO;
    unique case (opcode)
      OP_RORDER: begin
        // Only add/sub write back; jr, nop and unknown functs do not.
        if (funct == FN_ADD || funct == FN_SUB) begin
          we     = 1'b1;
          a3_src = A3_RD;
          wd_sel = WD_ALU;
        end
      end
      OP_ORI, OP_LUI: begin
        we     = 1'b1;
        a3_src = A3_RT;
        wd_sel = WD_ALU;
      end
      OP_LW: begin
        we     = 1'b1;
        a3_src = A3_RT;
        wd_sel = WD_DM;
      end
      OP_JAL: begin
        we     = 1'b1;
        a3_src = A3_RA;
        wd_sel = WD_PC8;
      end
      default: ;  // sw, beq and unknown opcodes: no write
    endcase
  end

endmodule

// File: rtl/mw_stage.sv
// -----------------------------------------------------------------------------
// mw_stage
// M/W pipeline register plus writeback formation. Captures the M-stage bundle,
// decodes it in W and drives the GRF write port, the W-stage forwarding
// qualifier and Tnew, and counts retired (non-bubble) instructions.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   en          in   capture enable (0 holds every register)
//   flush       in   load a bubble on the next edge (beats en)
//   Instr_M     in   M-stage instruction
//   PC_M        in   M-stage PC
//   ALUout_M    in   M-stage ALU result
//   DMout_M     in   data-memory read word
//   Tnew_M      in   M-stage Tnew
//   Instr_W     out  registered instruction
//   PC_W        out  registered PC
//   GRF_WE      out  GRF write enable
//   GRF_A3      out  GRF write address
//   GRF_WD      out  GRF write data
//   Tnew_W      out  registered, saturating-decremented Tnew
//   fwd_valid   out  W holds a live register result for forwarding
//   retire_cnt  out  count of non-bubble instructions that reached W
// -----------------------------------------------------------------------------
module mw_stage
  import mw_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                flush,
  input  logic [31:0]         Instr_M,
  input  logic [31:0]         PC_M,
  input  logic [31:0]         ALUout_M,
  input  logic [31:0]         DMout_M,
  input  logic [TNEW_W-1:0]   Tnew_M,
  output logic [31:0]         Instr_W,
  output logic [31:0]         PC_W,
  output logic                GRF_WE,
  output logic [4:0]          GRF_A3,
  output logic [31:0]         GRF_WD,
  output logic [TNEW_W-1:0]   Tnew_W,
  output logic                fwd_valid,
  output logic [CNT_W-1:0]    retire_cnt
);

  // A bubble is a nop parked at the reset PC; reset and flush both load it.
  localparam w_regs_t BUBBLE = '{
    instr: '0, pc: RESET_PC, alu: '0, dm: '0, tnew: '0, valid: 1'b0
  };

  w_regs_t          w_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order; the asynchronous reset
  // clears every one of them, so no stale in-flight instruction survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q   <= BUBBLE;
      cnt_q <= '0;
    end else if (flush) begin
      w_q   <= BUBBLE;
    end else if (en) begin
      w_q <= '{
        instr: Instr_M,
        pc:    PC_M,
        alu:   ALUout_M,
        dm:    DMout_M,
        tnew:  tnew_dec(Tnew_M),
        valid: (Instr_M != '0)
      };
      if (Instr_M != '0) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback formation (combinational from the W registers)
  // ---------------------------------------------------------------------------
  logic    dec_we;
  a3_src_e a3_src;
  wd_sel_e wd_sel;

  wb_decode u_wb_decode (
    .opcode (w_q.instr[31:26]),
    .funct  (w_q.instr[5:0]),
    .we     (dec_we),
    .a3_src (a3_src),
    .wd_sel (wd_sel)
  );

  logic [4:0]  a3_dec;
  logic [31:0] wd_dec;
  logic        we_final;

  always_comb begin
    a3_dec = '0;
    unique case (a3_src)
      A3_RD:   a3_dec = w_q.instr[15:11];
      A3_RT:   a3_dec = w_q.instr[20:16];
      A3_RA:   a3_dec = RA_IDX;
      default: a3_dec = '0;
    endcase

    wd_dec = '0;
    unique case (wd_sel)
      WD_ALU:  wd_dec = w_q.alu;
      WD_DM:   wd_dec = w_q.dm;
      WD_PC8:  wd_dec = w_q.pc + 32'd8;  // wraps modulo 2^32
      default: wd_dec = '0;
    endcase

    // Writes to $0 are dropped entirely, and a bubble never writes.
    we_final = dec_we && w_q.valid && (a3_dec != 5'd0);
  end

  assign GRF_WE     = we_final;
  assign GRF_A3     = we_final ? a3_dec : 5'd0;
  assign GRF_WD     = we_final ? wd_dec : 32'd0;
  assign fwd_valid  = we_final;
  assign Instr_W    = w_q.instr;
  assign PC_W       = w_q.pc;
  assign Tnew_W     = w_q.tnew;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mw_stage.sv
// -----------------------------------------------------------------------------
// tb_mw_stage
// Self-checking bench for mw_stage. A reference model written directly from
// the MIPS writeback rules tracks the W-stage contents; a second instance with
// a 4-bit counter exercises counter wrap-around.
// -----------------------------------------------------------------------------
module tb_mw_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] Instr_M = '0;
  logic [31:0] PC_M = '0;
  logic [31:0] ALUout_M = '0;
  logic [31:0] DMout_M = '0;
  logic [1:0]  Tnew_M = '0;

  logic [31:0] Instr_W, PC_W, GRF_WD;
  logic        GRF_WE, fwd_valid;
  logic [4:0]  GRF_A3;
  logic [1:0]  Tnew_W;
  logic [31:0] retire_cnt;

  logic [31:0] instr_w_s, pc_w_s, grf_wd_s;
  logic        grf_we_s, fwd_valid_s;
  logic [4:0]  grf_a3_s;
  logic [1:0]  tnew_w_s;
  logic [3:0]  cnt_s;

  mw_stage #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .Instr_M(Instr_M), .PC_M(PC_M), .ALUout_M(ALUout_M), .DMout_M(DMout_M),
    .Tnew_M(Tnew_M), .Instr_W(Instr_W), .PC_W(PC_W), .GRF_WE(GRF_WE),
    .GRF_A3(GRF_A3), .GRF_WD(GRF_WD), .Tnew_W(Tnew_W), .fwd_valid(fwd_valid),
    .retire_cnt(retire_cnt)
  );

  mw_stage #(.RESET_PC(RESET_PC), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .Instr_M(Instr_M), .PC_M(PC_M), .ALUout_M(ALUout_M), .DMout_M(DMout_M),
    .Tnew_M(Tnew_M), .Instr_W(instr_w_s), .PC_W(pc_w_s), .GRF_WE(grf_we_s),
    .GRF_A3(grf_a3_s), .GRF_WD(grf_wd_s), .Tnew_W(tnew_w_s),
    .fwd_valid(fwd_valid_s), .retire_cnt(cnt_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Reference model: what the W stage should currently hold.
  // ---------------------------------------------------------------------------
  logic [31:0] m_instr, m_pc, m_alu, m_dm, m_cnt;
  logic [1:0]  m_tnew;
  logic [3:0]  m_cnt_s;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic model_reset();
    m_instr = '0; m_pc = RESET_PC; m_alu = '0; m_dm = '0; m_tnew = '0;
    m_cnt = '0; m_cnt_s = '0;
  endtask

  // Effect of one rising edge with the inputs currently applied.
  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else if (flush) begin
      m_instr = '0; m_pc = RESET_PC; m_alu = '0; m_dm = '0; m_tnew = '0;
    end else if (en) begin
      m_instr = Instr_M; m_pc = PC_M; m_alu = ALUout_M; m_dm = DMout_M;
      m_tnew  = (Tnew_M == 2'd0) ? 2'd0 : Tnew_M - 2'd1;
      if (Instr_M != 32'd0) begin
        m_cnt   = m_cnt + 1;
        m_cnt_s = m_cnt_s + 1;
      end
    end
  endtask

  // {we, a3, wd} the register file should see for the modelled W instruction.
  function automatic logic [37:0] exp_wb();
    logic [5:0]  op = m_instr[31:26];
    logic [5:0]  fn = m_instr[5:0];
    logic [4:0]  a3 = 5'd0;
    logic [31:0] wd = 32'd0;
    case (op)
      6'h00:        if (fn == 6'h20 || fn == 6'h22) begin a3 = m_instr[15:11]; wd = m_alu; end
      6'h0D, 6'h0F: begin a3 = m_instr[20:16]; wd = m_alu; end
      6'h23:        begin a3 = m_instr[20:16]; wd = m_dm; end
      6'h03:        begin a3 = 5'd31; wd = m_pc + 32'd8; end
      default: ;
    endcase
    if (a3 == 5'd0) return 38'd0;
    return {1'b1, a3, wd};
  endfunction

  function automatic logic [136:0] exp_vec();
    logic [37:0] wb = exp_wb();
    return {m_instr, m_pc, wb, m_tnew, wb[37], m_cnt};
  endfunction

  function automatic logic [136:0] obs_vec();
    return {Instr_W, PC_W, GRF_WE, GRF_A3, GRF_WD, Tnew_W, fwd_valid, retire_cnt};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs = rand_reg();
    logic [4:0]  rt = rand_reg();
    logic [4:0]  rd = rand_reg();
    logic [15:0] imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  return enc_r(rs, rt, rd, 6'h20);
      1:  return enc_r(rs, rt, rd, 6'h22);
      2:  return enc_i(6'h0D, rs, rt, imm);
      3:  return enc_i(6'h0F, 5'd0, rt, imm);
      4:  return enc_i(6'h23, rs, rt, imm);
      5:  return enc_i(6'h2B, rs, rt, imm);
      6:  return enc_i(6'h04, rs, rt, imm);
      7:  return {6'h03, 26'($urandom)};
      8:  return enc_r(rs, 5'd0, rd, 6'h08);
      9:  return 32'd0;
      10: return enc_i(6'h3F, rs, rt, imm);
      default: return enc_r(rs, rt, rd, 6'h21);  // addu: not decoded here
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; flush = 1'($urandom);
      Instr_M = $urandom; PC_M = $urandom; ALUout_M = $urandom; DMout_M = $urandom;
      Tnew_M = 2'($urandom);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL reset_state[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (PC_W !== 32'h3000 || retire_cnt !== 32'd0 || GRF_WE !== 1'b0 || Instr_W !== 32'd0) begin
        failures++; $display("FAIL reset_const[%0d]: pc=%h cnt=%0d we=%b instr=%h", i, PC_W, retire_cnt, GRF_WE, Instr_W);
      end
    end
    reset = 1'b1;
    en = 1'b1; flush = 1'b0;
    Instr_M = enc_r(5'd1, 5'd2, 5'd3, 6'h20); PC_M = 32'h3000; ALUout_M = 32'd5; DMout_M = $urandom;
    Tnew_M = 2'd0;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL add_model: got %h want %h", obs_vec(), exp_vec());
    end
    checks++;
    if (GRF_WE !== 1'b1 || GRF_A3 !== 5'd3 || GRF_WD !== 32'd5 || retire_cnt !== 32'd1) begin
      failures++; $display("FAIL add_wb: we=%b a3=%0d wd=%h cnt=%0d want 1/3/5/1", GRF_WE, GRF_A3, GRF_WD, retire_cnt);
    end
  endtask

  task automatic test_lw();
    Instr_M = enc_i(6'h23, 5'd29, 5'd8, 16'h0010);
    ALUout_M = 32'h10; DMout_M = 32'hDEAD_BEEF; Tnew_M = 2'd1; PC_M = 32'h3004;
    tick();
    checks++;
    if (GRF_WD !== 32'hDEAD_BEEF || GRF_A3 !== 5'd8 || Tnew_W !== 2'd0 || fwd_valid !== 1'b1) begin
      failures++; $display("FAIL lw_wb: wd=%h a3=%0d tnew=%0d fwd=%b", GRF_WD, GRF_A3, Tnew_W, fwd_valid);
    end
    // Tnew 3 must come out as 2.
    Instr_M = enc_i(6'h0D, 5'd1, 5'd9, 16'h00FF); ALUout_M = 32'h1FF; Tnew_M = 2'd3;
    tick();
    checks++;
    if (Tnew_W !== 2'd2 || GRF_A3 !== 5'd9 || GRF_WD !== 32'h1FF) begin
      failures++; $display("FAIL ori_tnew: tnew=%0d a3=%0d wd=%h want 2/9/1ff", Tnew_W, GRF_A3, GRF_WD);
    end
  endtask

  task automatic test_jal_zero();
    Instr_M = {6'h03, 26'h0000C00}; PC_M = 32'h3004; ALUout_M = $urandom; Tnew_M = 2'd0;
    tick();
    checks++;
    if (GRF_WE !== 1'b1 || GRF_A3 !== 5'd31 || GRF_WD !== 32'h300C) begin
      failures++; $display("FAIL jal_wb: we=%b a3=%0d wd=%h want 1/31/300c", GRF_WE, GRF_A3, GRF_WD);
    end
    Instr_M = enc_i(6'h0D, 5'd0, 5'd0, 16'd7); ALUout_M = 32'd7;
    tick();
    checks++;
    if (GRF_WE !== 1'b0 || GRF_A3 !== 5'd0 || GRF_WD !== 32'd0 || fwd_valid !== 1'b0 || retire_cnt !== 32'd5) begin
      failures++; $display("FAIL ori_zero: we=%b a3=%0d wd=%h fwd=%b cnt=%0d want 0/0/0/0/5",
                           GRF_WE, GRF_A3, GRF_WD, fwd_valid, retire_cnt);
    end
  endtask

  task automatic test_no_write();
    logic [31:0] pool [4];
    pool[0] = enc_i(6'h2B, 5'd1, 5'd5, 16'h0004);
    pool[1] = enc_i(6'h04, 5'd1, 5'd2, 16'h0003);
    pool[2] = enc_r(5'd31, 5'd0, 5'd7, 6'h08);
    pool[3] = enc_i(6'h3F, 5'd3, 5'd6, 16'h1234);
    foreach (pool[i]) begin
      Instr_M = pool[i]; ALUout_M = $urandom; DMout_M = $urandom; PC_M = $urandom;
      tick();
      checks++;
      if (GRF_WE !== 1'b0 || obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL no_write[%0d]: we=%b got %h want %h", i, GRF_WE, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_hold_flush();
    logic [31:0] held_cnt;
    Instr_M = enc_r(5'd1, 5'd2, 5'd4, 6'h20); ALUout_M = 32'hA5A5_0001; PC_M = 32'h3040;
    tick();
    held_cnt = m_cnt;
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Instr_M = rand_instr() | 32'h1; ALUout_M = $urandom; PC_M = $urandom;
      tick();
      checks++;
      if (GRF_A3 !== 5'd4 || GRF_WD !== 32'hA5A5_0001 || retire_cnt !== held_cnt || PC_W !== 32'h3040) begin
        failures++; $display("FAIL hold[%0d]: a3=%0d wd=%h cnt=%0d pc=%h", i, GRF_A3, GRF_WD, retire_cnt, PC_W);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (GRF_WE !== 1'b0 || Instr_W !== 32'd0 || PC_W !== 32'h3000 || retire_cnt !== held_cnt) begin
      failures++; $display("FAIL flush: we=%b instr=%h pc=%h cnt=%0d", GRF_WE, Instr_W, PC_W, retire_cnt);
    end
    flush = 1'b0; en = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      Instr_M = rand_instr();
      PC_M = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      ALUout_M = $urandom; DMout_M = $urandom; Tnew_M = 2'($urandom);
      tick();
      checks++;
      if (obs_vec() !== exp_vec() || cnt_s !== m_cnt_s) begin
        failures++; $display("FAIL random[%0d]: got %h/%h want %h/%h", i, obs_vec(), cnt_s, exp_vec(), m_cnt_s);
      end
    end
    en = 1'b1; flush = 1'b0;
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      Instr_M = enc_r(5'd1, 5'd2, 5'(i + 1), 6'h22); ALUout_M = $urandom;
      tick();
    end
    checks++;
    if (cnt_s !== 4'hF || retire_cnt !== 32'd15) begin
      failures++; $display("FAIL wrap_pre: small=%0d big=%0d want 15/15", cnt_s, retire_cnt);
    end
    Instr_M = {6'h03, 26'h0}; PC_M = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (cnt_s !== 4'h0 || retire_cnt !== 32'd16 || GRF_WD !== 32'h4) begin
      failures++; $display("FAIL wrap: small=%0d big=%0d wd=%h want 0/16/4", cnt_s, retire_cnt, GRF_WD);
    end
  endtask

  task automatic test_async_reset();
    Instr_M = enc_r(5'd1, 5'd2, 5'd5, 6'h20); ALUout_M = 32'h1234_5678; PC_M = 32'h3100;
    tick();
    checks++;
    if (GRF_WE !== 1'b1 || GRF_A3 !== 5'd5) begin
      failures++; $display("FAIL pre_async: we=%b a3=%0d want 1/5", GRF_WE, GRF_A3);
    end
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== exp_vec() || GRF_WE !== 1'b0 || PC_W !== 32'h3000 || retire_cnt !== 32'd0) begin
      failures++; $display("FAIL async_clear: got %h want %h", obs_vec(), exp_vec());
    end
    tick();
    checks++;
    if (GRF_WE !== 1'b0 || Instr_W !== 32'd0 || cnt_s !== 4'd0) begin
      failures++; $display("FAIL reset_held: we=%b instr=%h small=%0d", GRF_WE, Instr_W, cnt_s);
    end
    reset = 1'b1; en = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL post_release: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_jal_zero();
    test_no_write();
    test_hold_flush();
    test_random();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mw_stage.md
Name: mw_stage

Overview:
- M/W pipeline register plus writeback formation for the 5-stage MIPS core.
- Captures the M-stage instruction bundle on each clock edge.
- Decodes the captured instruction and drives the GRF write port: write enable, write address and write data.
- Supplies W-stage forwarding data and Tnew to the hazard unit, and keeps a retired-instruction counter for trace and debug.

Parameters:
RESET_PC, 32'h0000_3000, PC_W value held after reset and after flush
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
en  input  1  capture enable; 0 holds all registers
flush  input  1  load a bubble (nop) on the next edge
Instr_M  input  32  M-stage instruction
PC_M  input  32  M-stage PC
ALUout_M  input  32  M-stage ALU result
DMout_M  input  32  data-memory read word
Tnew_M  input  2  M-stage Tnew
Instr_W  output  32  registered instruction
PC_W  output  32  registered PC
GRF_WE  output  1  GRF write enable
GRF_A3  output  5  GRF write address
GRF_WD  output  32  GRF write data
Tnew_W  output  2  registered Tnew, saturating decrement of Tnew_M
fwd_valid  output  1  W stage holds a live register result usable for forwarding
retire_cnt  output  CNT_W  count of non-bubble instructions that reached W

Behaviour:
- Reset (reset==0, asynchronous), held until release:
  - Instr_W=0 (nop), PC_W=RESET_PC.
  - Internal ALU/DM registers =0, Tnew_W=0, retire_cnt=0, internal valid bit=0.
  - Therefore GRF_WE=0, GRF_A3=0, GRF_WD=0, fwd_valid=0.
- Priority on each rising edge: flush > en.
  - flush=1: load bubble (Instr=0, PC=RESET_PC, data=0, Tnew=0, valid=0), regardless of en.
  - flush=0, en=1: capture all M inputs.
    - Tnew_W <= (Tnew_M==0) ? 0 : Tnew_M-1.
    - valid <= (Instr_M != 0).
  - flush=0, en=0: hold everything, including retire_cnt.
- Latency: one cycle M->W. Writeback outputs are combinational from the W registers, within the same cycle.
- Decode (opcode=Instr_W[31:26], funct=Instr_W[5:0]):
  - add/sub (R-type): A3=rd, WD=ALU.
  - ori/lui: A3=rt, WD=ALU.
  - lw: A3=rt, WD=DM.
  - jal: A3=31, WD=PC_W+8.
  - sw, beq, jr, nop and unknown opcodes: WE=0, A3=0, WD=0.
- $0 rule: if the decoded A3==0 then GRF_WE=0, and GRF_A3/GRF_WD are forced to 0. GRF_WE never asserts for a bubble.
- fwd_valid = GRF_WE.
- retire_cnt increments by 1 on each edge that captures (en=1, flush=0) a nonzero Instr_M. It wraps modulo 2^CNT_W with no saturation.
- PC_W+8 uses 32-bit modulo arithmetic and wraps silently.
- Reset asserted mid-stream discards the in-flight instruction. No GRF write occurs for it.

Decomposition:
- Shared header/package holds:
  - Opcode constants: Rorder, Ori, Lw, Sw, Beq, Lui, Jal.
  - Funct constants: Add, Sub, Jr, Nop.
  - Constants RA_IDX=31 and the Tnew width.
- One natural sub-module: wb_decode, the combinational decoder mapping Instr_W to WE, A3 source and WD select.

Test Plan:
1. reset=0 for 3 cycles with random inputs -> all outputs 0, PC_W=32'h3000, retire_cnt=0. Release reset, feed add $3,$1,$2 with ALUout_M=5 -> next cycle GRF_WE=1, A3=3, WD=5, retire_cnt=1.
2. lw $8 with DMout_M=32'hDEAD_BEEF, ALUout_M=32'h10, Tnew_M=1 -> GRF_WD=32'hDEADBEEF, A3=8, Tnew_W=0.
3. jal with PC_M=32'h3004 -> A3=31, WD=32'h300C. ori $0,$0,7 -> GRF_WE=0, A3=0, fwd_valid=0, retire_cnt still increments.
4. sw/beq/jr/unknown opcode 6'h3F -> GRF_WE=0 for each. en=0 for 2 cycles -> outputs and retire_cnt frozen.
5. flush=1 together with en=0 while add is held -> next edge bubble loaded (GRF_WE=0, Instr_W=0), retire_cnt unchanged.
6. Preload retire_cnt to all-ones via a force, capture one instruction -> wraps to 0. Assert reset asynchronously mid-cycle -> outputs clear before the next clock edge.
